// File: rtl/cnn_mem_rd_arb.sv
// Round-robin arbiter sharing one memory read port between the picture-window (client 0)
// and weight-window (client 1) fetch paths, with a data-phase watchdog.
module cnn_mem_rd_arb #(
    parameter int ADDR_WIDTH   = 19,
    parameter int MEM_DATA_BUS = 128,
    parameter int SIZE_W       = 5,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              cl_req,
    input  logic [ADDR_WIDTH-1:0]   cl_addr0,
    input  logic [ADDR_WIDTH-1:0]   cl_addr1,
    input  logic [SIZE_W-1:0]       cl_size0,
    input  logic [SIZE_W-1:0]       cl_size1,
    output logic [1:0]              cl_gnt,
    output logic [1:0]              cl_valid,
    output logic [1:0]              cl_last,
    output logic [MEM_DATA_BUS-1:0] cl_data,
    output logic                    mem_req,
    output logic [ADDR_WIDTH-1:0]   mem_start_addr,
    output logic [SIZE_W-1:0]       mem_size_bytes,
    input  logic                    mem_gnt,
    input  logic                    mem_valid,
    input  logic                    mem_last,
    input  logic [MEM_DATA_BUS-1:0] mem_data,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    // The favoured client wins if it is requesting, otherwise the other one does.
    function automatic logic pick_winner(input logic [1:0] req, input logic ptr);
        logic win;
        if (req[ptr]) begin
            win = ptr;
        end else begin
            win = ~ptr;
        end
        return win;
    endfunction

    function automatic logic [1:0] to_onehot(input logic idx);
        logic [1:0] vec;
        vec = 2'b00;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    state_t                  state_r;
    logic                    owner_r;
    logic                    rr_ptr_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [SIZE_W-1:0]       size_r;
    logic                    mem_req_r;
    logic [WD_W-1:0]         wdog_r;
    logic [1:0]              zero_done_r;

    logic                    winner_s;
    logic                    arb_go_s;
    logic [ADDR_WIDTH-1:0]   addr_sel_s;
    logic [SIZE_W-1:0]       size_sel_s;
    logic                    data_done_s;
    logic                    timeout_s;
    logic [1:0]              cl_gnt_s;
    logic [1:0]              cl_valid_s;
    logic [1:0]              cl_last_s;

    // Arbitration: blocked during the zero-size completion pulse so a still-high request is not re-served.
    always_comb begin
        winner_s = pick_winner(cl_req, rr_ptr_r);
        arb_go_s = (state_r == ST_IDLE) && (cl_req != 2'b00) && (zero_done_r == 2'b00);
        if (winner_s) begin
            addr_sel_s = cl_addr1;
            size_sel_s = cl_size1;
        end else begin
            addr_sel_s = cl_addr0;
            size_sel_s = cl_size0;
        end
    end

    // Data-phase termination conditions: real last beat or watchdog expiry.
    always_comb begin
        data_done_s = (state_r == ST_DATA) && mem_valid && mem_last;
        timeout_s   = (state_r == ST_DATA) && !mem_valid && (wdog_r == WD_LIMIT);
    end

    // Main controller: state, ownership, latched request, memory request and watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            owner_r     <= 1'b0;
            rr_ptr_r    <= 1'b0;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            size_r      <= {SIZE_W{1'b0}};
            mem_req_r   <= 1'b0;
            wdog_r      <= {WD_W{1'b0}};
            zero_done_r <= 2'b00;
        end else begin
            zero_done_r <= 2'b00;
            case (state_r)
                ST_IDLE: begin
                    wdog_r <= {WD_W{1'b0}};
                    if (arb_go_s) begin
                        owner_r <= winner_s;
                        addr_r  <= addr_sel_s;
                        size_r  <= size_sel_s;
                        if (size_sel_s != {SIZE_W{1'b0}}) begin
                            state_r   <= ST_ISSUE;
                            mem_req_r <= 1'b1;
                        end else begin
                            zero_done_r <= to_onehot(winner_s);
                            rr_ptr_r    <= ~winner_s;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (mem_gnt) begin
                        mem_req_r <= 1'b0;
                        wdog_r    <= {WD_W{1'b0}};
                        state_r   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (data_done_s || timeout_s) begin
                        state_r  <= ST_IDLE;
                        rr_ptr_r <= ~owner_r;
                        wdog_r   <= {WD_W{1'b0}};
                    end else if (mem_valid) begin
                        wdog_r <= {WD_W{1'b0}};
                    end else begin
                        wdog_r <= wdog_r + WD_W'(1);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_req_r <= 1'b0;
                    wdog_r    <= {WD_W{1'b0}};
                end
            endcase
        end
    end

    // Client-side handshake: grant and beat routing to the current owner only.
    always_comb begin
        cl_gnt_s   = zero_done_r;
        cl_valid_s = 2'b00;
        cl_last_s  = zero_done_r;
        case (state_r)
            ST_ISSUE: begin
                cl_gnt_s[owner_r] = mem_gnt;
            end
            ST_DATA: begin
                cl_valid_s[owner_r] = mem_valid;
                cl_last_s[owner_r]  = data_done_s || timeout_s;
            end
            default: begin
                cl_gnt_s   = zero_done_r;
                cl_valid_s = 2'b00;
                cl_last_s  = zero_done_r;
            end
        endcase
    end

    assign cl_gnt         = cl_gnt_s;
    assign cl_valid       = cl_valid_s;
    assign cl_last        = cl_last_s;
    assign cl_data        = mem_data;
    assign mem_req        = mem_req_r;
    assign mem_start_addr = addr_r;
    assign mem_size_bytes = size_r;
    assign busy           = (state_r != ST_IDLE);
    assign timeout_err    = timeout_s;

endmodule

// File: tb/tb_cnn_mem_rd_arb.sv
// Self-checking bench for cnn_mem_rd_arb: randomized requests and memory responses checked
// against a transaction-level round-robin model.
module tb_cnn_mem_rd_arb;

    localparam int AW = 19;
    localparam int DW = 128;
    localparam int SW = 5;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    cl_req;
    logic [AW-1:0] cl_addr0, cl_addr1;
    logic [SW-1:0] cl_size0, cl_size1;
    logic [1:0]    cl_gnt, cl_valid, cl_last;
    logic [DW-1:0] cl_data;
    logic          mem_req;
    logic [AW-1:0] mem_start_addr;
    logic [SW-1:0] mem_size_bytes;
    logic          mem_gnt, mem_valid, mem_last;
    logic [DW-1:0] mem_data;
    logic          busy, timeout_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic rr_model;

    cnn_mem_rd_arb #(.ADDR_WIDTH(AW), .MEM_DATA_BUS(DW), .SIZE_W(SW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .cl_req(cl_req),
        .cl_addr0(cl_addr0), .cl_addr1(cl_addr1), .cl_size0(cl_size0), .cl_size1(cl_size1),
        .cl_gnt(cl_gnt), .cl_valid(cl_valid), .cl_last(cl_last), .cl_data(cl_data),
        .mem_req(mem_req), .mem_start_addr(mem_start_addr), .mem_size_bytes(mem_size_bytes),
        .mem_gnt(mem_gnt), .mem_valid(mem_valid), .mem_last(mem_last), .mem_data(mem_data),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Client-side outputs must never name both clients at once.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            n_checks++;
            if (!$onehot0(cl_gnt) || !$onehot0(cl_valid) || !$onehot0(cl_last)) begin
                n_fail++;
                $display("FAIL onehot: gnt=%b valid=%b last=%b, required at most one bit each", cl_gnt, cl_valid, cl_last);
            end
        end
    end

    function automatic logic [1:0] oh(input logic w);
        return w ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_request(input logic w, input int min_size);
        if (w) begin
            cl_addr1 = AW'($urandom);
            cl_size1 = SW'($urandom_range(min_size, 20));
        end else begin
            cl_addr0 = AW'($urandom);
            cl_size0 = SW'($urandom_range(min_size, 20));
        end
        cl_req[w] = 1'b1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        cl_req = 2'b00; mem_gnt = 1'b0; mem_valid = 1'b0; mem_last = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        rr_model = 1'b0;
    endtask

    // One whole transaction, starting in IDLE; rearm: 0 drop request, 1 new nonzero request, 2 any size.
    task automatic run_txn(input int gnt_lat, input int nbeats, input int rearm, input bit noise);
        logic          w;
        logic [AW-1:0] ea;
        logic [SW-1:0] es;
        logic [DW-1:0] d;
        w  = cl_req[rr_model] ? rr_model : ~rr_model;
        ea = w ? cl_addr1 : cl_addr0;
        es = w ? cl_size1 : cl_size0;
        tick();
        if (es == 5'd0) begin
            n_checks++;
            if (cl_gnt !== oh(w) || cl_last !== oh(w) || cl_valid !== 2'b00) begin
                n_fail++;
                $display("FAIL zero_size_pulse: gnt=%b last=%b valid=%b, required gnt=last=%b valid=00", cl_gnt, cl_last, cl_valid, oh(w));
            end
            n_checks++;
            if (mem_req !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_size_no_mem: mem_req=%b busy=%b, required 0 0", mem_req, busy);
            end
            cl_req[w] = 1'b0;
            if (rearm != 0) new_request(w, (rearm == 1) ? 1 : 0);
            tick();
            n_checks++;
            if (cl_gnt !== 2'b00 || cl_last !== 2'b00 || mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_size_single: gnt=%b last=%b mem_req=%b, required 00 00 0", cl_gnt, cl_last, mem_req);
            end
        end else begin
            n_checks++;
            if (mem_req !== 1'b1 || mem_start_addr !== ea || mem_size_bytes !== es || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL issue_latch: req=%b addr=%h size=%0d busy=%b, required 1 %h %0d 1", mem_req, mem_start_addr, mem_size_bytes, busy, ea, es);
            end
            for (int i = 0; i < gnt_lat; i++) begin
                mem_valid = noise ? 1'($urandom) : 1'b0;
                mem_last  = 1'($urandom);
                mem_data  = rand_data();
                #1;
                n_checks++;
                if (cl_gnt !== 2'b00 || cl_valid !== 2'b00 || cl_last !== 2'b00 || mem_req !== 1'b1) begin
                    n_fail++;
                    $display("FAIL issue_wait: gnt=%b valid=%b last=%b req=%b, required 00 00 00 1", cl_gnt, cl_valid, cl_last, mem_req);
                end
                tick();
            end
            mem_valid = 1'b0; mem_last = 1'b0; mem_gnt = 1'b1;
            #1;
            n_checks++;
            if (cl_gnt !== oh(w) || mem_req !== 1'b1) begin
                n_fail++;
                $display("FAIL grant: gnt=%b req=%b, required %b 1", cl_gnt, mem_req, oh(w));
            end
            tick();
            mem_gnt = 1'b0;
            cl_req[w] = 1'b0;
            if (rearm != 0) new_request(w, (rearm == 1) ? 1 : 0);
            for (int b = 0; b < nbeats; b++) begin
                repeat ($urandom_range(0, 3)) begin
                    #1;
                    n_checks++;
                    if (cl_valid !== 2'b00 || cl_last !== 2'b00 || mem_req !== 1'b0) begin
                        n_fail++;
                        $display("FAIL data_gap: valid=%b last=%b req=%b, required 00 00 0", cl_valid, cl_last, mem_req);
                    end
                    tick();
                end
                d = rand_data();
                mem_valid = 1'b1; mem_last = (b == nbeats - 1); mem_data = d;
                #1;
                n_checks++;
                if (cl_valid !== oh(w) || cl_last !== (mem_last ? oh(w) : 2'b00) || cl_data !== d) begin
                    n_fail++;
                    $display("FAIL beat: valid=%b last=%b data=%h, required %b %b %h", cl_valid, cl_last, cl_data, oh(w), mem_last ? oh(w) : 2'b00, d);
                end
                tick();
                mem_valid = 1'b0; mem_last = 1'b0;
            end
            n_checks++;
            if (busy !== 1'b0 || mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL complete_idle: busy=%b req=%b, required 0 0", busy, mem_req);
            end
        end
        rr_model = ~w;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (cl_gnt !== 2'b00 || cl_valid !== 2'b00 || cl_last !== 2'b00 || mem_req !== 1'b0 ||
            mem_start_addr !== 19'd0 || mem_size_bytes !== 5'd0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: gnt=%b valid=%b last=%b req=%b addr=%h size=%0d busy=%b to=%b, required all 0",
                     cl_gnt, cl_valid, cl_last, mem_req, mem_start_addr, mem_size_bytes, busy, timeout_err);
        end
    endtask

    task automatic test_single();
        cl_addr0 = 19'h00100; cl_size0 = 5'd4; cl_req = 2'b01;
        run_txn(3, 1, 0, 0);
    endtask

    task automatic test_fairness();
        apply_reset();
        new_request(1'b0, 1);
        new_request(1'b1, 1);
        for (int i = 0; i < 6; i++) run_txn($urandom_range(0, 4), $urandom_range(1, 3), 1, 1);
        cl_req = 2'b00;
    endtask

    task automatic test_zero_size();
        cl_addr1 = AW'($urandom); cl_size1 = 5'd0; cl_req = 2'b10;
        run_txn(0, 0, 0, 0);
    endtask

    task automatic test_watchdog();
        cl_addr1 = AW'($urandom); cl_size1 = 5'd8; cl_req = 2'b10;
        run_txn_hang();
        mem_valid = 1'b1; mem_last = 1'b1; mem_data = rand_data();
        #1;
        n_checks++;
        if (cl_valid !== 2'b00 || cl_last !== 2'b00) begin
            n_fail++;
            $display("FAIL late_beat_dropped: valid=%b last=%b, required 00 00", cl_valid, cl_last);
        end
        mem_valid = 1'b0; mem_last = 1'b0;
        run_txn(1, 2, 0, 0);
    endtask

    task automatic run_txn_hang();
        tick();
        mem_gnt = 1'b1;
        #1;
        n_checks++;
        if (cl_gnt !== 2'b10) begin
            n_fail++;
            $display("FAIL wd_grant: gnt=%b, required 10", cl_gnt);
        end
        tick();
        mem_gnt = 1'b0;
        cl_req = 2'b00;
        new_request(1'b0, 1);
        for (int c = 1; c < TO; c++) begin
            n_checks++;
            if (timeout_err !== 1'b0 || cl_last !== 2'b00 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL wd_early cycle %0d: to=%b last=%b busy=%b, required 0 00 1", c, timeout_err, cl_last, busy);
            end
            tick();
        end
        n_checks++;
        if (timeout_err !== 1'b1 || cl_last !== 2'b10 || cl_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL wd_abort: to=%b last=%b valid=%b, required 1 10 00", timeout_err, cl_last, cl_valid);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b0 || cl_last !== 2'b00) begin
            n_fail++;
            $display("FAIL wd_after: busy=%b to=%b last=%b, required 0 0 00", busy, timeout_err, cl_last);
        end
        rr_model = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] d;
        cl_addr1 = AW'($urandom); cl_size1 = 5'd20; cl_req = 2'b10;
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; cl_req = 2'b00;
        d = rand_data();
        mem_valid = 1'b1; mem_last = 1'b0; mem_data = d;
        #1;
        n_checks++;
        if (cl_valid !== 2'b10 || cl_data !== d) begin
            n_fail++;
            $display("FAIL pre_reset_beat: valid=%b data=%h, required 10 %h", cl_valid, cl_data, d);
        end
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (cl_gnt !== 2'b00 || cl_valid !== 2'b00 || cl_last !== 2'b00 || mem_req !== 1'b0 ||
            mem_start_addr !== 19'd0 || mem_size_bytes !== 5'd0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: gnt=%b valid=%b last=%b req=%b addr=%h size=%0d busy=%b, required all 0",
                     cl_gnt, cl_valid, cl_last, mem_req, mem_start_addr, mem_size_bytes, busy);
        end
        mem_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        rr_model = 1'b0;
        new_request(1'b0, 1);
        new_request(1'b1, 1);
        run_txn(1, 1, 0, 0);
        run_txn(0, 1, 0, 0);
    endtask

    task automatic test_idle_noise();
        cl_req = 2'b00;
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1'b1; mem_last = 1'($urandom); mem_data = rand_data();
            #1;
            n_checks++;
            if (cl_valid !== 2'b00 || cl_last !== 2'b00 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_noise: valid=%b last=%b busy=%b, required 00 00 0", cl_valid, cl_last, busy);
            end
            tick();
        end
        mem_valid = 1'b0; mem_last = 1'b0;
    endtask

    task automatic test_random();
        for (int t = 0; t < 14; t++) begin
            for (int c = 0; c < 2; c++) begin
                if (cl_req[c] == 1'b0 && $urandom_range(0, 1) == 1) new_request(c[0], 0);
            end
            if (cl_req == 2'b00) new_request(1'($urandom), 0);
            run_txn($urandom_range(0, 5), $urandom_range(1, 4), 0, 1);
        end
        cl_req = 2'b00;
    endtask

    initial begin
        rst_n = 1'b0;
        cl_req = 2'b00; cl_addr0 = '0; cl_addr1 = '0; cl_size0 = '0; cl_size1 = '0;
        mem_gnt = 1'b0; mem_valid = 1'b0; mem_last = 1'b0; mem_data = '0;
        rr_model = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_zero_size();
        test_watchdog();
        test_async_reset();
        test_idle_noise();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
